// File: rtl/gpio.sv
// gpio: parametrised general-purpose I/O peripheral on the data-memory bus.
// Eight-word register window at BASE_ADDR:
//   0x00 IN, 0x04 OUT, 0x08 DIR, 0x0C SET, 0x10 CLR, 0x14 TGL,
//   0x18 IRQ_EN, 0x1C IRQ_STAT (write 1 to clear).
// Optional feature macro: GPIO_IRQ_EN builds the rising-edge detector together
// with the IRQ_EN and IRQ_STAT registers. Without it, those offsets read 0,
// writes to them are ignored, and irq is tied low.
// Bus reads are registered: data_o is valid one cycle after addr.
module gpio #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [31:0]      addr,
  input  logic [31:0]      data_i,
  output logic [31:0]      data_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  // Word offsets within the window (addr[4:2]).
  localparam logic [2:0] OFF_IN   = 3'd0;
  localparam logic [2:0] OFF_OUT  = 3'd1;
  localparam logic [2:0] OFF_DIR  = 3'd2;
  localparam logic [2:0] OFF_SET  = 3'd3;
  localparam logic [2:0] OFF_CLR  = 3'd4;
  localparam logic [2:0] OFF_TGL  = 3'd5;
  localparam logic [2:0] OFF_IEN  = 3'd6;
  localparam logic [2:0] OFF_STAT = 3'd7;

  // Zero-extend a pin-wide value onto the 32-bit bus. The two-step form stays
  // legal when WIDTH is 32, where a zero-width replication would not be.
  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = 32'h0000_0000;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  // Address decode: the window is 32-byte aligned, so bits [31:5] select it
  // and bits [4:2] select the word. Bits [1:0] are ignored.
  logic             hit_s;
  logic [2:0]       offset_s;
  logic             wr_s;
  logic [WIDTH-1:0] wdata_s;

  assign hit_s    = (addr[31:5] == BASE_ADDR[31:5]);
  assign offset_s = addr[4:2];
  assign wr_s     = en & hit_s;
  assign wdata_s  = data_i[WIDTH-1:0];

  // Byte-lane address bits and write bits above WIDTH are deliberately unused.
  logic unused_bus_bits_s;
  assign unused_bus_bits_s = ^{addr[1:0], data_i};

  // Architectural registers.
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [31:0]      rdata_q, rdata_d;

  // Input synchroniser: stage 0 samples the pins, the last stage is the
  // metastability-safe value seen by IN and by the edge detector.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  sync_out_s;

  assign sync_d     = {sync_q[SYNC_STAGES-2:0], gpio_i};
  assign sync_out_s = sync_q[SYNC_STAGES-1];

`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] ien_q, ien_d;
  logic [WIDTH-1:0] stat_q, stat_d;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] w1c_mask_s;

  assign rise_s = sync_out_s & ~prev_q;
`endif

  // Next-state logic for OUT/DIR, including atomic set/clear/toggle.
  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
    if (wr_s) begin
      case (offset_s)
        OFF_OUT: out_d = wdata_s;
        OFF_DIR: dir_d = wdata_s;
        OFF_SET: out_d = out_q | wdata_s;
        OFF_CLR: out_d = out_q & ~wdata_s;
        OFF_TGL: out_d = out_q ^ wdata_s;
        default: begin
          out_d = out_q;
          dir_d = dir_q;
        end
      endcase
    end else begin
      out_d = out_q;
      dir_d = dir_q;
    end
  end

`ifdef GPIO_IRQ_EN
  // Next-state logic for IRQ_EN and IRQ_STAT; a new edge beats a W1C clear.
  always_comb begin
    ien_d      = ien_q;
    w1c_mask_s = '0;
    if (wr_s && (offset_s == OFF_IEN)) begin
      ien_d = wdata_s;
    end else begin
      ien_d = ien_q;
    end
    if (wr_s && (offset_s == OFF_STAT)) begin
      w1c_mask_s = wdata_s;
    end else begin
      w1c_mask_s = '0;
    end
    stat_d = (stat_q & ~w1c_mask_s) | rise_s;
  end
`endif

  // Read mux: selects the register addressed this cycle, registered below.
  always_comb begin
    rdata_d = 32'h0000_0000;
    if (hit_s) begin
      case (offset_s)
        OFF_IN:   rdata_d = zext(sync_out_s);
        OFF_OUT:  rdata_d = zext(out_q);
        OFF_DIR:  rdata_d = zext(dir_q);
`ifdef GPIO_IRQ_EN
        OFF_IEN:  rdata_d = zext(ien_q);
        OFF_STAT: rdata_d = zext(stat_q);
`endif
        default:  rdata_d = 32'h0000_0000;
      endcase
    end else begin
      rdata_d = 32'h0000_0000;
    end
  end

  // Core state: OUT, DIR, read data and synchroniser, with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q   <= '0;
      dir_q   <= '0;
      rdata_q <= 32'h0000_0000;
      sync_q  <= '0;
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      rdata_q <= rdata_d;
      sync_q  <= sync_d;
    end
  end

`ifdef GPIO_IRQ_EN
  // Interrupt state: edge history, enable mask and sticky status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= '0;
      ien_q  <= '0;
      stat_q <= '0;
    end else begin
      prev_q <= sync_out_s;
      ien_q  <= ien_d;
      stat_q <= stat_d;
    end
  end

  assign irq = |(stat_q & ien_q);
`else
  assign irq = 1'b0;
`endif

  assign data_o  = rdata_q;
  assign gpio_o  = out_q;
  assign gpio_oe = dir_q;

endmodule

// File: tb/tb_gpio.sv
// tb_gpio: directed self-checking bench for gpio (WIDTH=8, SYNC_STAGES=2).
// The interrupt section runs when GPIO_IRQ_EN is defined; otherwise the
// disabled-feature behaviour is checked instead.
module tb_gpio;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam logic [31:0] A_IN   = BASE + 32'h00;
  localparam logic [31:0] A_OUT  = BASE + 32'h04;
  localparam logic [31:0] A_DIR  = BASE + 32'h08;
  localparam logic [31:0] A_SET  = BASE + 32'h0C;
  localparam logic [31:0] A_CLR  = BASE + 32'h10;
  localparam logic [31:0] A_TGL  = BASE + 32'h14;
  localparam logic [31:0] A_IEN  = BASE + 32'h18;
  localparam logic [31:0] A_STAT = BASE + 32'h1C;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] addr;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic [7:0]  gpio_i;
  logic [7:0]  gpio_o;
  logic [7:0]  gpio_oe;
  logic        irq;

  int checks;
  int failures;

  gpio #(
    .BASE_ADDR  (BASE),
    .WIDTH      (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .addr   (addr),
    .data_i (data_i),
    .data_o (data_o),
    .gpio_i (gpio_i),
    .gpio_o (gpio_o),
    .gpio_oe(gpio_oe),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle bus write.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    en     = 1'b1;
    addr   = a;
    data_i = d;
    tick();
    en     = 1'b0;
    data_i = 32'h0000_0000;
  endtask

  // Registered read: present addr, one edge later data_o holds the value.
  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    tick();
    check_eq(tag, data_o, exp);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    addr     = 32'h0000_0000;
    data_i   = 32'h0000_0000;
    gpio_i   = 8'h00;

    // Reset held for two cycles.
    tick();
    tick();
    check_eq("rst_gpio_o", 32'(gpio_o), 32'h0);
    check_eq("rst_gpio_oe", 32'(gpio_oe), 32'h0);
    check_eq("rst_irq", 32'(irq), 32'h0);
    check_eq("rst_data_o", data_o, 32'h0);
    rst_n = 1'b1;
    tick();

    // Atomic operations.
    wr(A_OUT, 32'h0000_00A5);
    check_eq("out_write", 32'(gpio_o), 32'h0000_00A5);
    wr(A_SET, 32'h0000_000F);
    check_eq("set", 32'(gpio_o), 32'h0000_00AF);
    wr(A_CLR, 32'h0000_0081);
    check_eq("clr", 32'(gpio_o), 32'h0000_002E);
    wr(A_TGL, 32'h0000_00FF);
    check_eq("tgl", 32'(gpio_o), 32'h0000_00D1);
    rd_check("out_read", A_OUT, 32'h0000_00D1);

    // Same-cycle read returns old value, next cycle returns new value.
    wr(A_OUT, 32'h0000_0033);
    check_eq("same_cycle_old", data_o, 32'h0000_00D1);
    check_eq("out_write2", 32'(gpio_o), 32'h0000_0033);
    tick();
    check_eq("raw_new", data_o, 32'h0000_0033);

    // Width masking and write-only reads.
    wr(A_DIR, 32'hFFFF_FF3C);
    check_eq("dir_oe", 32'(gpio_oe), 32'h0000_003C);
    check_eq("dir_keeps_out", 32'(gpio_o), 32'h0000_0033);
    rd_check("dir_read", A_DIR, 32'h0000_003C);
    rd_check("set_read0", A_SET, 32'h0);
    rd_check("clr_read0", A_CLR, 32'h0);
    rd_check("tgl_read0", A_TGL, 32'h0);

    // Unmapped addresses and writes to IN are ignored.
    rd_check("unmapped_read", 32'h0000_0204, 32'h0);
    wr(A_IN, 32'h0000_00FF);
    check_eq("in_write_ign", 32'(gpio_o), 32'h0000_0033);
    wr(32'h0000_0204, 32'h0000_0000);
    check_eq("other_win_ign", 32'(gpio_o), 32'h0000_0033);
    wr(A_OUT + 32'h2, 32'h0000_0044);
    check_eq("lowbits_ign", 32'(gpio_o), 32'h0000_0044);

    // Input synchroniser latency: visible in data_o after edge k+2.
    addr = A_IN;
    tick();
    check_eq("in_idle", data_o, 32'h0);
    gpio_i = 8'h5A;
    tick();
    check_eq("in_k", data_o, 32'h0);
    tick();
    check_eq("in_k1", data_o, 32'h0);
    tick();
    check_eq("in_k2", data_o, 32'h0000_005A);

`ifdef GPIO_IRQ_EN
    // Interrupt: enable bit 0, clear leftover status from the 0x5A edge.
    tick();
    wr(A_IEN, 32'h0000_0001);
    wr(A_STAT, 32'h0000_00FF);
    check_eq("irq_idle", 32'(irq), 32'h0);
    rd_check("stat_clear", A_STAT, 32'h0);
    rd_check("ien_read", A_IEN, 32'h0000_0001);
    gpio_i = 8'h5B;
    tick();
    check_eq("irq_e1", 32'(irq), 32'h0);
    tick();
    check_eq("irq_e2", 32'(irq), 32'h0);
    tick();
    check_eq("irq_e3", 32'(irq), 32'h1);
    rd_check("stat_set", A_STAT, 32'h0000_0001);

    // Drop bit 0, then re-raise it so the edge lands with a W1C.
    gpio_i = 8'h5A;
    for (int i = 0; i < 4; i++) tick();
    check_eq("stat_sticky", 32'(irq), 32'h1);
    gpio_i = 8'h5B;
    tick();
    tick();
    wr(A_STAT, 32'h0000_0001);
    check_eq("set_wins_irq", 32'(irq), 32'h1);
    rd_check("set_wins_stat", A_STAT, 32'h0000_0001);

    // Clean clear.
    wr(A_STAT, 32'h0000_0001);
    check_eq("w1c_irq", 32'(irq), 32'h0);
    rd_check("w1c_stat", A_STAT, 32'h0);

    // Status sets without enable, irq stays low.
    gpio_i = 8'h00;
    for (int i = 0; i < 4; i++) tick();
    gpio_i = 8'h80;
    for (int i = 0; i < 4; i++) tick();
    check_eq("dis_irq", 32'(irq), 32'h0);
    rd_check("dis_stat", A_STAT, 32'h0000_0080);
`else
    // Feature absent: irq stays low and the IRQ offsets read zero.
    gpio_i = 8'h00;
    for (int i = 0; i < 4; i++) tick();
    gpio_i = 8'hFF;
    for (int i = 0; i < 4; i++) tick();
    check_eq("noirq_irq", 32'(irq), 32'h0);
    wr(A_IEN, 32'h0000_00FF);
    check_eq("noirq_irq2", 32'(irq), 32'h0);
    rd_check("noirq_ien", A_IEN, 32'h0);
    rd_check("noirq_stat", A_STAT, 32'h0);
    check_eq("noirq_out", 32'(gpio_o), 32'h0000_0044);
`endif

    // A write during reset is discarded and reset clears outputs.
    rst_n = 1'b0;
    wr(A_OUT, 32'h0000_0077);
    check_eq("rstwr_out", 32'(gpio_o), 32'h0);
    check_eq("rstwr_oe", 32'(gpio_oe), 32'h0);
    check_eq("rstwr_irq", 32'(irq), 32'h0);
    check_eq("rstwr_data", data_o, 32'h0);
    rst_n = 1'b1;
    rd_check("post_rst_out", A_OUT, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio.md
# gpio

Parametrised general-purpose I/O peripheral, successor to the single-register parallel port. Sits on the core's data-memory bus at `BASE_ADDR` and provides per-pin direction control, atomic set/clear/toggle of outputs, a metastability-hardened input path and optional rising-edge interrupts. All bus reads are registered, so read data arrives one cycle after the address.

## Interface
- `BASE_ADDR`, 32'h00000100: base of the 8-word register window; must be 32-byte aligned.
- `WIDTH`, 32: pin count, 1..32.
- `SYNC_STAGES`, 2: input synchroniser depth, 2..4.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `en`  in  1  write strobe; a write occurs when `en`=1 and `addr` hits a writable register.
- `addr`  in  32  byte address, word-aligned; bits [1:0] ignored.
- `data_i`  in  32  write data.
- `data_o`  out  32  registered read data.
- `gpio_i`  in  WIDTH  asynchronous pin inputs.
- `gpio_o`  out  WIDTH  output register value.
- `gpio_oe`  out  WIDTH  output enable (= DIR), 1 = drive.
- `irq`  out  1  level interrupt, high while any enabled status bit is set.

## Operation
- Register map (offset from `BASE_ADDR`): 0x00 IN (RO), 0x04 OUT (RW), 0x08 DIR (RW), 0x0C SET (WO), 0x10 CLR (WO), 0x14 TGL (WO), 0x18 IRQ_EN (RW), 0x1C IRQ_STAT (RW1C).
- SET: OUT |= data_i; CLR: OUT &= ~data_i; TGL: OUT ^= data_i.
- Only bits [WIDTH-1:0] are stored; upper write bits are ignored and reads zero-extend.
- WO registers and unmapped addresses read 0; writes to unmapped addresses or IN are ignored.
- `data_o` is updated every cycle from the current `addr`, regardless of `en`.
- `gpio_o` reflects OUT on every bit regardless of DIR; external pad logic uses `gpio_oe`.
- Input path: `gpio_i` passes through a `SYNC_STAGES`-deep flop chain (sync) and then a one-flop history (prev). IN reads the sync output.
- Edge detect: rise = sync & ~prev; each rising bit sets IRQ_STAT[i] whatever IRQ_EN says.
- IRQ_STAT write: bits with data_i=1 clear. If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- `irq` = |(IRQ_STAT & IRQ_EN), combinational from registers.
- Reset (`rst_n`=0 at a clock edge): OUT, DIR, IRQ_EN, IRQ_STAT, sync chain, prev and `data_o` all go to 0. `gpio_o`=0, `gpio_oe`=0, `irq`=0.
- Because prev resets to 0, a pin held high through reset flags a rising edge `SYNC_STAGES`+1 cycles after release.
- A write in the cycle where `rst_n`=0 is discarded.

## Timing
- Write: a register updates at the edge where `en`=1. `gpio_o`/`gpio_oe` change right after that edge.
- Read latency: 1 cycle. `addr` presented before edge k gives `data_o` valid after edge k.
- Read-after-write of the same register on consecutive cycles returns the new value. A same-cycle read returns the old value.
- Input latency: a `gpio_i` change stable before edge k appears at the sync output after edge k+SYNC_STAGES-1. It is readable via IN in `data_o` after edge k+SYNC_STAGES.
- Edge latency: IRQ_STAT[i] and `irq` (if enabled) go high after edge k+SYNC_STAGES.
- Pulses shorter than one cycle may be missed. Pulses of two or more cycles are always captured.

## Configuration
- `GPIO_IRQ_EN` defined: edge detector, IRQ_EN and IRQ_STAT are built as described.
- `GPIO_IRQ_EN` undefined: prev, IRQ_EN and IRQ_STAT are not built. Offsets 0x18/0x1C read 0 and ignore writes, and `irq` is tied 0. The IN/OUT/DIR/SET/CLR/TGL path is unchanged.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `gpio_i`=0 -> `gpio_o`=0, `gpio_oe`=0, `irq`=0, `data_o`=0.
- Atomic ops (WIDTH=8): write OUT=0xA5, SET 0x0F, CLR 0x81, TGL 0xFF -> `gpio_o` reads 0xAF, then 0x2E, then 0xD1; OUT read returns 0x000000D1.
- Width masking (WIDTH=8): write DIR=0xFFFF_FF3C -> `gpio_oe`=0x3C, DIR read 0x0000003C; read of SET offset returns 0.
- Input sync (SYNC_STAGES=2): drive `gpio_i`=0x5A before edge k with `addr`=IN -> `data_o`=0x5A first after edge k+2, not earlier.
- Interrupt (GPIO_IRQ_EN, IRQ_EN=0x01): raise `gpio_i[0]` -> IRQ_STAT=0x01 and `irq`=1 after 3 edges. Then W1C 0x01 on the same cycle as a new rising edge on bit 0 -> IRQ_STAT stays 0x01. A clean W1C clears it and drops `irq`.
- Build without GPIO_IRQ_EN: toggle `gpio_i` -> `irq` stays 0 and reads of 0x18/0x1C return 0.
